// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the miniRV fetch stage: next-PC select codes,
// fetch FSM encodings and the reset instruction.
package ifetch_unit_pkg;

   localparam logic [2:0]  NPC_PC4  = 3'd0;
   localparam logic [2:0]  NPC_COM  = 3'd1;
   localparam logic [2:0]  NPC_JMP  = 3'd2;
   localparam logic [2:0]  NPC_JMPR = 3'd3;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC selection. Every target is word-aligned on the way
// out; only a JALR target with bit 1 set is reported as misaligned.
module ifetch_unit_npc
   import ifetch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [2:0]      npc_op,
   input  logic            br_taken,
   input  logic [XLEN-1:0] ext,
   input  logic [XLEN-1:0] alu_c,
   output logic [XLEN-1:0] npc,
   output logic [XLEN-1:0] pc4,
   output logic            jalr_misalign
);

   logic [XLEN-1:0] w_pc_ext;
   logic [XLEN-1:0] w_raw;

   assign pc4      = pc + XLEN'(32'd4);
   assign w_pc_ext = pc + ext;

   always_comb begin
      w_raw         = pc4;
      jalr_misalign = 1'b0;
      case (npc_op)
         NPC_COM:  w_raw = br_taken ? w_pc_ext : pc4;
         NPC_JMP:  w_raw = w_pc_ext;
         NPC_JMPR: begin
            w_raw         = alu_c;
            jalr_misalign = alu_c[1];
         end
         default:  w_raw = pc4;
      endcase
   end

   // Clearing both low bits covers the JALR bit-0 clear and the forced alignment.
   assign npc = w_raw & {{(XLEN-2){1'b1}}, 2'b00};

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: one outstanding imem request, holds the returned word for
// decode and advances the PC when decode accepts it.
//   state  | meaning
//   S_REQ  | request for pc presented, waiting for imem_req_ready
//   S_WAIT | request accepted, waiting for imem_rsp_valid
//   S_HOLD | instruction held for decode, waiting for inst_ready
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   input  logic [2:0]      npc_op,
   input  logic            br_taken,
   input  logic [XLEN-1:0] ext,
   input  logic [XLEN-1:0] alu_c,
   output logic            misalign,
   output logic [31:0]     fetch_cnt
);

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_npc;
   logic [31:0]     r_inst;
   logic [31:0]     r_fetch_cnt;
   logic            r_misalign;
   logic            w_jalr_misalign;
   logic            w_accept;
   logic            w_capture;

   ifetch_unit_npc #(.XLEN(XLEN)) u_npc (
      .pc            (r_pc),
      .npc_op        (npc_op),
      .br_taken      (br_taken),
      .ext           (ext),
      .alu_c         (alu_c),
      .npc           (w_npc),
      .pc4           (pc4),
      .jalr_misalign (w_jalr_misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_REQ;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      imem_req_valid = 1'b0;
      inst_valid     = 1'b0;
      w_accept       = 1'b0;
      w_capture      = 1'b0;
      case (r_state)
         S_REQ: begin
            // Reset state is S_REQ, but no request may leave while rst is high.
            imem_req_valid = !rst;
            if (imem_req_ready) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_capture = imem_rsp_valid;
            if (imem_rsp_valid) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            inst_valid = 1'b1;
            w_accept   = inst_ready;
            if (inst_ready) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_inst      <= INST_NOP;
         r_misalign  <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         if (w_capture) r_inst <= imem_rsp_data;
         if (w_accept) begin
            r_pc        <= w_npc;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_jalr_misalign) r_misalign <= 1'b1;
         end
      end
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign inst      = r_inst;
   assign misalign  = r_misalign;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: bench-side imem responder with
// programmable stall/latency and a next-PC reference model.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst, pc, pc4;
   logic [2:0]  npc_op = NPC_PC4;
   logic        br_taken = 1'b0;
   logic [31:0] ext = '0;
   logic [31:0] alu_c = '0;
   logic        misalign;
   logic [31:0] fetch_cnt;

   logic        rst2 = 1'b1;
   logic        req_valid2;
   logic        req_ready2 = 1'b0;
   logic [31:0] addr2;
   logic        rsp_valid2 = 1'b0;
   logic [31:0] rsp_data2 = '0;
   logic        inst_valid2;
   logic        inst_ready2 = 1'b0;
   logic [31:0] inst2, pc2, pc4_2;
   logic        misalign2;
   logic [31:0] fetch_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc), .pc4(pc4),
      .npc_op(npc_op), .br_taken(br_taken), .ext(ext), .alu_c(alu_c),
      .misalign(misalign), .fetch_cnt(fetch_cnt)
   );

   ifetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst2),
      .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_addr(addr2),
      .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
      .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst(inst2), .pc(pc2), .pc4(pc4_2),
      .npc_op(NPC_PC4), .br_taken(1'b0), .ext(32'h0), .alu_c(32'h0),
      .misalign(misalign2), .fetch_cnt(fetch_cnt2)
   );

   // ---------------- instruction memory model ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   int          mem_lat = 1;
   int          mem_stall = 0;
   int          lat_left = 0;
   int          stall_cnt = 0;
   int          cyc = 0;
   bit          busy = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] hs_addr[$];
   int          hs_cyc[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      if (rst) begin
         busy      = 1'b0;
         stall_cnt = 0;
      end else if (busy) begin
         if (lat_left <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(req_addr);
            busy           = 1'b0;
         end else begin
            lat_left--;
         end
      end else if (imem_req_valid) begin
         if (stall_cnt >= mem_stall) begin
            imem_req_ready = 1'b1;
            busy           = 1'b1;
            lat_left       = mem_lat;
            req_addr       = imem_addr;
            stall_cnt      = 0;
            hs_addr.push_back(imem_addr);
            hs_cyc.push_back(cyc + 1);
         end else begin
            stall_cnt++;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_pc  = '0;
   int          exp_cnt = 0;
   bit          exp_mis = 1'b0;

   function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [2:0] op,
                                           input bit br, input logic [31:0] e, input logic [31:0] a);
      logic [31:0] t;
      case (op)
         3'd1:    t = br ? p + e : p + 32'd4;
         3'd2:    t = p + e;
         3'd3:    t = a;
         default: t = p + 32'd4;
      endcase
      return t & 32'hFFFF_FFFC;
   endfunction

   task automatic model_step(input logic [2:0] op, input bit br, input logic [31:0] e, input logic [31:0] a);
      if (op == 3'd3 && a[1]) exp_mis = 1'b1;
      exp_pc = ref_npc(exp_pc, op, br, e, a);
      exp_cnt++;
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic do_accept(input logic [2:0] op, input bit br, input logic [31:0] e, input logic [31:0] a,
                            input int hold, output logic [31:0] o_pc, output logic [31:0] o_inst,
                            output bit stable, output bit tmo);
      int n = 0;
      stable = 1'b1;
      tmo    = 1'b0;
      o_pc   = '0;
      o_inst = '0;
      while (!inst_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!inst_valid) begin
         tmo = 1'b1;
         return;
      end
      o_pc   = pc;
      o_inst = inst;
      npc_op   = 3'($urandom);
      br_taken = 1'($urandom);
      ext      = $urandom;
      alu_c    = $urandom;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!inst_valid || pc !== o_pc || inst !== o_inst || pc4 !== o_pc + 32'd4) stable = 1'b0;
      end
      npc_op     = op;
      br_taken   = br;
      ext        = e;
      alu_c      = a;
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic wait_hs(input int n, output bit tmo);
      int k = 0;
      while (hs_addr.size() < n && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      tmo = (hs_addr.size() < n);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      hs_addr.delete();
      hs_cyc.delete();
      repeat (2) @(negedge clk);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
      checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h want 00000013", inst); end
      checks++; if (misalign !== 1'b0 || fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_mis_cnt: got %b/%h want 0/0", misalign, fetch_cnt); end
      rst     = 1'b0;
      exp_pc  = 32'h0;
      exp_cnt = 0;
      exp_mis = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] o_pc, o_inst;
      bit stable, tmo;
      mem_lat   = 1;
      mem_stall = 0;
      for (int i = 0; i < 3; i++) begin
         do_accept(NPC_PC4, 1'b0, 32'h0, 32'h0, 0, o_pc, o_inst, stable, tmo);
         checks++; if (tmo) begin errors++; $display("FAIL seq_timeout: no inst_valid at instr %0d", i); return; end
         checks++; if (o_inst !== mem_word(o_pc) || o_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_inst: pc %h inst %h want pc %h", o_pc, o_inst, 32'(4 * i)); end
         model_step(NPC_PC4, 1'b0, 32'h0, 32'h0);
      end
      checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_fetch_cnt: got %0d want 3", fetch_cnt); end
      wait_hs(4, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL seq_req_timeout: %0d requests want 4", hs_addr.size()); return; end
      for (int i = 0; i < 4; i++) begin
         checks++; if (hs_addr[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, hs_addr[i], 32'(4 * i)); end
      end
      checks++; if (hs_cyc[2] - hs_cyc[1] != 3) begin errors++; $display("FAIL seq_min_latency: got %0d cycles want 3", hs_cyc[2] - hs_cyc[1]); end
   endtask

   task automatic test_branch();
      logic [31:0] o_pc, o_inst;
      bit stable, tmo;
      for (int pass = 0; pass < 2; pass++) begin
         do_accept(NPC_JMPR, 1'b0, 32'h0, 32'h10, 0, o_pc, o_inst, stable, tmo);
         model_step(NPC_JMPR, 1'b0, 32'h0, 32'h10);
         do_accept(NPC_COM, pass == 0, 32'hFFFF_FFF8, 32'h0, 1, o_pc, o_inst, stable, tmo);
         checks++; if (tmo || o_pc !== 32'h10) begin errors++; $display("FAIL br_pc: got %h want 00000010", o_pc); end
         model_step(NPC_COM, pass == 0, 32'hFFFF_FFF8, 32'h0);
         wait_hs(exp_cnt + 1, tmo);
         checks++;
         if (tmo) begin errors++; $display("FAIL br_timeout: no request after branch"); return; end
         if (hs_addr[exp_cnt] !== (pass == 0 ? 32'h08 : 32'h14)) begin
            errors++; $display("FAIL br_target taken=%0d: got %h want %h", pass == 0, hs_addr[exp_cnt], (pass == 0 ? 32'h08 : 32'h14));
         end
      end
   endtask

   task automatic test_jump();
      logic [31:0] o_pc, o_inst;
      bit stable, tmo;
      do_accept(NPC_JMPR, 1'b0, 32'h0, 32'h20, 0, o_pc, o_inst, stable, tmo);
      model_step(NPC_JMPR, 1'b0, 32'h0, 32'h20);
      do_accept(NPC_JMP, 1'b0, 32'h100, 32'h0, 0, o_pc, o_inst, stable, tmo);
      model_step(NPC_JMP, 1'b0, 32'h100, 32'h0);
      wait_hs(exp_cnt + 1, tmo);
      checks++; if (tmo || o_pc !== 32'h20 || hs_addr[exp_cnt] !== 32'h120) begin errors++; $display("FAIL jal_target: pc %h next %h want 00000020/00000120", o_pc, tmo ? 32'h0 : hs_addr[exp_cnt]); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jal_misalign: got %b want 0", misalign); end
      do_accept(NPC_JMPR, 1'b0, 32'h0, 32'h0000_0207, 0, o_pc, o_inst, stable, tmo);
      model_step(NPC_JMPR, 1'b0, 32'h0, 32'h0000_0207);
      wait_hs(exp_cnt + 1, tmo);
      checks++; if (tmo || hs_addr[exp_cnt] !== 32'h204) begin errors++; $display("FAIL jalr_target: got %h want 00000204", tmo ? 32'h0 : hs_addr[exp_cnt]); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL jalr_misalign: got %b want 1", misalign); end
      for (int i = 0; i < 2; i++) begin
         do_accept(NPC_PC4, 1'b0, 32'h0, 32'h0, 0, o_pc, o_inst, stable, tmo);
         model_step(NPC_PC4, 1'b0, 32'h0, 32'h0);
      end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b want 1", misalign); end
   endtask

   task automatic test_backpressure();
      logic [31:0] o_pc, o_inst;
      bit stable, tmo, bad;
      int st;
      mem_stall = 5;
      mem_lat   = 3;
      do_accept(NPC_PC4, 1'b0, 32'h0, 32'h0, 0, o_pc, o_inst, stable, tmo);
      model_step(NPC_PC4, 1'b0, 32'h0, 32'h0);
      for (int it = 0; it < 2; it++) begin
         st  = 0;
         bad = 1'b0;
         while (st < 50) begin
            @(negedge clk);
            #1;
            if (hs_addr.size() > exp_cnt) break;
            st++;
            if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) bad = 1'b1;
         end
         checks++; if (bad) begin errors++; $display("FAIL bp_addr_stable: addr %h valid %b want %h/1", imem_addr, imem_req_valid, exp_pc); end
         checks++; if (st < 4 || st > 5) begin errors++; $display("FAIL bp_stall_len: got %0d cycles want 4..5", st); end
         do_accept(NPC_PC4, 1'b0, 32'h0, 32'h0, 4, o_pc, o_inst, stable, tmo);
         checks++; if (tmo || !stable) begin errors++; $display("FAIL bp_hold_stable: tmo %b stable %b want 0/1", tmo, stable); end
         checks++; if (o_pc !== exp_pc || o_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL bp_inst: pc %h inst %h want %h/%h", o_pc, o_inst, exp_pc, mem_word(exp_pc)); end
         model_step(NPC_PC4, 1'b0, 32'h0, 32'h0);
         checks++; if (hs_addr.size() != exp_cnt) begin errors++; $display("FAIL bp_one_req: %0d requests want %0d", hs_addr.size(), exp_cnt); end
      end
      mem_stall = 0;
      mem_lat   = 1;
   endtask

   task automatic test_random();
      logic [31:0] o_pc, o_inst, e, a;
      logic [2:0]  op;
      bit stable, tmo, br;
      int hold;
      for (int i = 0; i < 40; i++) begin
         mem_lat   = $urandom_range(1, 4);
         mem_stall = $urandom_range(0, 3);
         op   = 3'($urandom_range(0, 7));
         br   = 1'($urandom);
         e    = $urandom;
         a    = $urandom;
         hold = $urandom_range(0, 3);
         do_accept(op, br, e, a, hold, o_pc, o_inst, stable, tmo);
         checks++; if (tmo) begin errors++; $display("FAIL rnd_timeout: iteration %0d", i); return; end
         checks++; if (o_pc !== exp_pc || o_inst !== mem_word(exp_pc) || !stable) begin
            errors++; $display("FAIL rnd_inst %0d: pc %h inst %h stable %b want %h/%h/1", i, o_pc, o_inst, stable, exp_pc, mem_word(exp_pc));
         end
         model_step(op, br, e, a);
         checks++; if (fetch_cnt !== 32'(exp_cnt) || misalign !== exp_mis) begin
            errors++; $display("FAIL rnd_cnt_mis %0d: cnt %0d mis %b want %0d/%b", i, fetch_cnt, misalign, exp_cnt, exp_mis);
         end
         wait_hs(exp_cnt + 1, tmo);
         checks++; if (tmo || hs_addr[exp_cnt] !== exp_pc) begin
            errors++; $display("FAIL rnd_req_addr %0d: got %h want %h", i, tmo ? 32'h0 : hs_addr[exp_cnt], exp_pc);
         end
      end
      mem_lat   = 1;
      mem_stall = 0;
   endtask

   task automatic test_async_reset();
      logic [31:0] o_pc, o_inst;
      bit stable, tmo;
      mem_lat = 6;
      do_accept(NPC_JMPR, 1'b0, 32'h0, 32'h100, 0, o_pc, o_inst, stable, tmo);
      model_step(NPC_JMPR, 1'b0, 32'h0, 32'h100);
      wait_hs(exp_cnt + 1, tmo);
      @(posedge clk);
      #2;
      checks++; if (tmo || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h100) begin
         errors++; $display("FAIL ar_in_wait: req %b iv %b pc %h want 0/0/00000100", imem_req_valid, inst_valid, pc);
      end
      rst = 1'b1;
      #1;
      checks++; if (inst_valid !== 1'b0 || pc !== 32'h0 || imem_req_valid !== 1'b0) begin
         errors++; $display("FAIL ar_immediate: iv %b pc %h req %b want 0/00000000/0", inst_valid, pc, imem_req_valid);
      end
      checks++; if (misalign !== 1'b0 || fetch_cnt !== 32'h0) begin errors++; $display("FAIL ar_clear: mis %b cnt %h want 0/0", misalign, fetch_cnt); end
      @(negedge clk);
      @(negedge clk);
      hs_addr.delete();
      hs_cyc.delete();
      rst     = 1'b0;
      exp_pc  = 32'h0;
      exp_cnt = 0;
      exp_mis = 1'b0;
      mem_lat = 1;
      do_accept(NPC_PC4, 1'b0, 32'h0, 32'h0, 0, o_pc, o_inst, stable, tmo);
      checks++; if (tmo || o_pc !== 32'h0 || o_inst !== mem_word(32'h0) || hs_addr.size() < 1 || hs_addr[0] !== 32'h0) begin
         errors++; $display("FAIL ar_first_fetch: pc %h inst %h want 00000000/%h", o_pc, o_inst, mem_word(32'h0));
      end
      model_step(NPC_PC4, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_wrap();
      rst2 = 1'b1;
      @(negedge clk);
      checks++; if (req_valid2 !== 1'b0 || pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset: req %b pc %h want 0/fffffffc", req_valid2, pc2); end
      rst2 = 1'b0;
      #1;
      checks++; if (req_valid2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: req %b addr %h want 1/fffffffc", req_valid2, addr2); end
      req_ready2 = 1'b1;
      @(negedge clk);
      req_ready2 = 1'b0;
      rsp_valid2 = 1'b1;
      rsp_data2  = 32'hCAFE_0001;
      force dut2.r_fetch_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      rsp_valid2 = 1'b0;
      release dut2.r_fetch_cnt;
      #1;
      checks++; if (inst_valid2 !== 1'b1 || inst2 !== 32'hCAFE_0001 || pc4_2 !== 32'h0) begin
         errors++; $display("FAIL wrap_hold: iv %b inst %h pc4 %h want 1/cafe0001/00000000", inst_valid2, inst2, pc4_2);
      end
      rsp_valid2 = 1'b1;
      rsp_data2  = 32'hDEAD_BEEF;
      @(negedge clk);
      rsp_valid2 = 1'b0;
      #1;
      checks++; if (inst2 !== 32'hCAFE_0001 || inst_valid2 !== 1'b1) begin errors++; $display("FAIL hold_ignore_rsp: inst %h want cafe0001", inst2); end
      checks++; if (fetch_cnt2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: cnt %h want ffffffff", fetch_cnt2); end
      inst_ready2 = 1'b1;
      @(negedge clk);
      inst_ready2 = 1'b0;
      #1;
      checks++; if (fetch_cnt2 !== 32'h0) begin errors++; $display("FAIL cnt_wrap: got %h want 00000000", fetch_cnt2); end
      checks++; if (req_valid2 !== 1'b1 || addr2 !== 32'h0 || pc2 !== 32'h0) begin errors++; $display("FAIL pc_wrap: req %b addr %h want 1/00000000", req_valid2, addr2); end
      rsp_valid2 = 1'b1;
      @(negedge clk);
      rsp_valid2 = 1'b0;
      #1;
      checks++; if (req_valid2 !== 1'b1 || inst_valid2 !== 1'b0 || inst2 !== 32'hCAFE_0001) begin
         errors++; $display("FAIL req_ignore_rsp: req %b iv %b inst %h want 1/0/cafe0001", req_valid2, inst_valid2, inst2);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_backpressure();
      test_random();
      test_async_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
